// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: frame width and RX FSM encodings.
package uart_pkg;

   localparam int UART_DATA_BITS = 8;

   localparam logic [2:0] RX_IDLE  = 3'd0;
   localparam logic [2:0] RX_START = 3'd1;
   localparam logic [2:0] RX_DATA  = 3'd2;
   localparam logic [2:0] RX_STOP  = 3'd3;
   localparam logic [2:0] RX_BREAK = 3'd4;

endpackage : uart_pkg

// File: rtl/uart_bit_sync.sv
// Multi-stage synchronizer for a single asynchronous level. Resets to 1 so an
// idle-high serial line does not look like a start bit coming out of reset.
module uart_bit_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_d,
   output logic o_q
);

   logic [SYNC_STAGES-1:0] sync_q;

   // Shift the raw level through the flop chain; the last stage is the safe copy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], i_d};
      end
   end

   assign o_q = sync_q[SYNC_STAGES-1];

endmodule : uart_bit_sync

// File: rtl/uart_rx_deser.sv
// UART 8N1 receive deserializer. Recovers LSB-first frames from the
// synchronized serial line, sampling every bit at its midpoint, and hands each
// good byte to the packer with a one-cycle request pulse.
//
// state    | meaning
// ---------+------------------------------------------------------------
// RX_IDLE  | line idle, waiting for sync_rx low
// RX_START | counting half a bit to re-check the start bit at mid-bit
// RX_DATA  | sampling 8 data bits, one every div clocks
// RX_STOP  | sampling the stop bit one div after the last data bit
// RX_BREAK | stop bit was low; wait for the line to return high
module uart_rx_deser
   import uart_pkg::*;
#(
   parameter int DIV_W       = 16,
   parameter int SYNC_STAGES = 2,
   parameter int MIN_DIV     = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      i_rx,
   input  logic [DIV_W-1:0]          i_clk_div,
   output logic [UART_DATA_BITS-1:0] o_rx_data,
   output logic                      o_fifo_rq,
   output logic                      o_frame_err,
   output logic                      o_rx_busy
);

   localparam logic [DIV_W-1:0] MIN_DIV_W = DIV_W'(MIN_DIV);
   localparam logic [DIV_W-1:0] CNT_ONE   = DIV_W'(1);
   localparam logic [2:0]       LAST_IDX  = 3'(UART_DATA_BITS - 1);

   logic                      sync_rx;
   logic [2:0]                state_q, state_d;
   logic [DIV_W-1:0]          bit_cnt_q, bit_cnt_d;
   logic [DIV_W-1:0]          div_q, div_d;
   logic [2:0]                bit_idx_q, bit_idx_d;
   logic [UART_DATA_BITS-1:0] shreg_q, shreg_d;
   logic [UART_DATA_BITS-1:0] rx_data_q, rx_data_d;
   logic                      fifo_rq_q, fifo_rq_d;
   logic                      frame_err_q, frame_err_d;

   logic [DIV_W-1:0]          div_in;
   logic [DIV_W-1:0]          half_m1;
   logic [DIV_W-1:0]          div_m1;

   uart_bit_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_rx_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .i_d   (i_rx),
      .o_q   (sync_rx)
   );

   // Divisor floor applied before latching; terminal counts derive from the latched copy.
   always_comb begin
      div_in  = (i_clk_div < MIN_DIV_W) ? MIN_DIV_W : i_clk_div;
      half_m1 = (div_q >> 1) - CNT_ONE;
      div_m1  = div_q - CNT_ONE;
   end

   // Next-state logic: bit timing, sampling, and output pulse generation.
   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      div_d       = div_q;
      bit_idx_d   = bit_idx_q;
      shreg_d     = shreg_q;
      rx_data_d   = rx_data_q;
      fifo_rq_d   = 1'b0;
      frame_err_d = 1'b0;

      case (state_q)
         RX_IDLE: begin
            if (!sync_rx) begin
               state_d   = RX_START;
               bit_cnt_d = '0;
               div_d     = div_in;
            end
         end

         RX_START: begin
            if (bit_cnt_q == half_m1) begin
               bit_cnt_d = '0;
               if (sync_rx) begin
                  state_d = RX_IDLE;
               end else begin
                  state_d   = RX_DATA;
                  bit_idx_d = '0;
               end
            end else begin
               bit_cnt_d = bit_cnt_q + CNT_ONE;
            end
         end

         RX_DATA: begin
            if (bit_cnt_q == div_m1) begin
               bit_cnt_d = '0;
               shreg_d   = {sync_rx, shreg_q[UART_DATA_BITS-1:1]};
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == LAST_IDX) begin
                  state_d = RX_STOP;
               end
            end else begin
               bit_cnt_d = bit_cnt_q + CNT_ONE;
            end
         end

         RX_STOP: begin
            if (bit_cnt_q == div_m1) begin
               bit_cnt_d = '0;
               if (sync_rx) begin
                  rx_data_d = shreg_q;
                  fifo_rq_d = 1'b1;
                  state_d   = RX_IDLE;
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = RX_BREAK;
               end
            end else begin
               bit_cnt_d = bit_cnt_q + CNT_ONE;
            end
         end

         RX_BREAK: begin
            // A held-low line must not be mistaken for a fresh start bit.
            if (sync_rx) begin
               state_d = RX_IDLE;
            end
         end

         default: begin
            state_d = RX_IDLE;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= RX_IDLE;
         bit_cnt_q   <= '0;
         div_q       <= MIN_DIV_W;
         bit_idx_q   <= '0;
         shreg_q     <= '0;
         rx_data_q   <= '0;
         fifo_rq_q   <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         div_q       <= div_d;
         bit_idx_q   <= bit_idx_d;
         shreg_q     <= shreg_d;
         rx_data_q   <= rx_data_d;
         fifo_rq_q   <= fifo_rq_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign o_rx_data   = rx_data_q;
   assign o_fifo_rq   = fifo_rq_q;
   assign o_frame_err = frame_err_q;
   assign o_rx_busy   = (state_q != RX_IDLE);

endmodule : uart_rx_deser

// File: tb/tb_uart_rx_deser.sv
// Self-checking bench for uart_rx_deser: a table of frames with expected
// results, hand-written corner sequences, and randomized frames checked
// against a frame-level reference model.
module tb_uart_rx_deser;

   localparam int SYNC = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_rx = 1'b1;
   logic [15:0] i_clk_div = 16'd16;
   logic [7:0]  o_rx_data;
   logic        o_fifo_rq;
   logic        o_frame_err;
   logic        o_rx_busy;

   uart_rx_deser #(
      .DIV_W       (16),
      .SYNC_STAGES (SYNC),
      .MIN_DIV     (4)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_rx        (i_rx),
      .i_clk_div   (i_clk_div),
      .o_rx_data   (o_rx_data),
      .o_fifo_rq   (o_fifo_rq),
      .o_frame_err (o_frame_err),
      .o_rx_busy   (o_rx_busy)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Pulse monitor, sampled on the falling edge.
   int         rq_cnt = 0;
   int         err_cnt = 0;
   int         viol = 0;
   int         last_rq_cyc = 0;
   bit         prev_pulse = 1'b0;
   logic [7:0] rx_q[$];

   always @(negedge clk) begin
      if (o_fifo_rq) begin
         rq_cnt++;
         last_rq_cyc = cyc;
         rx_q.push_back(o_rx_data);
      end
      if (o_frame_err) err_cnt++;
      if (o_fifo_rq && o_frame_err) viol++;
      if ((o_fifo_rq || o_frame_err) && prev_pulse) viol++;
      prev_pulse = o_fifo_rq || o_frame_err;
   end

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
   endtask

   function automatic int eff_div(input logic [15:0] d);
      return (d < 16'd4) ? 4 : int'(d);
   endfunction

   int start_cyc = 0;
   bit busy_in_break = 1'b0;

   // Drives one frame; each level is held for bl clocks.
   task automatic send_frame(input logic [7:0] d, input int bl, input bit stop,
                             input int hold, input int chg_bit, input logic [15:0] chg_div);
      @(negedge clk);
      i_rx = 1'b0;
      start_cyc = cyc;
      repeat (bl) @(negedge clk);
      for (int b = 0; b < 8; b++) begin
         if (b == chg_bit) i_clk_div = chg_div;
         i_rx = d[b];
         repeat (bl) @(negedge clk);
      end
      i_rx = stop;
      repeat (bl) @(negedge clk);
      if (!stop) begin
         repeat (hold) @(negedge clk);
         busy_in_break = o_rx_busy;
         i_rx = 1'b1;
      end
   endtask

   task automatic wait_idle(input string nm);
      int n = 0;
      while (o_rx_busy && n < 400) begin
         @(negedge clk);
         n++;
      end
      check(nm, 32'(n < 400), 32'd1);
      repeat (6) @(negedge clk);
   endtask

   typedef struct {
      logic [15:0] div;
      logic [7:0]  data;
      bit          stop;
      int          hold;
      int          exp_rq;
      int          exp_err;
      logic [7:0]  exp_data;
   } vec_t;

   vec_t vecs[7];

   initial begin
      int base_rq, base_err, lat, exp_lat, dv, k_rq, k_err;
      logic [7:0] exp4[4];
      logic [7:0] mdl_data;

      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, checks so far %0d", n_chk);
      $fatal(1, "watchdog");
   end

   initial begin
      int base_rq, base_err, lat, exp_lat, dv, hlen;
      int m_rq, m_err;
      logic [7:0] exp4[4];
      logic [7:0] mdl_data;
      logic [7:0] d;
      bit stop;
      int hold;
      logic [15:0] rdiv;

      vecs[0] = '{16'd16, 8'hA5, 1'b1, 0,  1, 0, 8'hA5};
      vecs[1] = '{16'd16, 8'h3C, 1'b0, 40, 0, 1, 8'hA5};
      vecs[2] = '{16'd4,  8'h00, 1'b1, 0,  1, 0, 8'h00};
      vecs[3] = '{16'd7,  8'hFF, 1'b1, 0,  1, 0, 8'hFF};
      vecs[4] = '{16'd5,  8'h5B, 1'b0, 3,  0, 1, 8'hFF};
      vecs[5] = '{16'd3,  8'h96, 1'b1, 0,  1, 0, 8'h96};
      vecs[6] = '{16'd9,  8'h01, 1'b1, 0,  1, 0, 8'h01};

      // Reset state.
      repeat (3) @(negedge clk);
      check("reset_outputs", {o_rx_data, o_fifo_rq, o_frame_err, o_rx_busy}, 32'd0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      // Table-driven frames.
      for (int i = 0; i < 7; i++) begin
         base_rq  = rq_cnt;
         base_err = err_cnt;
         i_clk_div = vecs[i].div;
         dv = eff_div(vecs[i].div);
         send_frame(vecs[i].data, dv, vecs[i].stop, vecs[i].hold, -1, 16'd0);
         wait_idle($sformatf("vec%0d_idle", i));
         check($sformatf("vec%0d_rq", i), 32'(rq_cnt - base_rq), 32'(vecs[i].exp_rq));
         check($sformatf("vec%0d_err", i), 32'(err_cnt - base_err), 32'(vecs[i].exp_err));
         check($sformatf("vec%0d_data", i), 32'(o_rx_data), 32'(vecs[i].exp_data));
         if (vecs[i].exp_rq == 1) begin
            // Start edge -> sync chain -> detect in IDLE, then half a bit plus
            // 8 data bits and the stop bit to the mid-stop sample.
            lat = last_rq_cyc - start_cyc;
            exp_lat = SYNC + 1 + dv / 2 + 9 * dv;
            check($sformatf("vec%0d_latency", i),
                  32'((lat == exp_lat || lat == exp_lat - 1) ? exp_lat : lat), 32'(exp_lat));
         end
         if (vecs[i].exp_err == 1) begin
            check($sformatf("vec%0d_busy_in_break", i), 32'(busy_in_break), 32'd1);
         end
      end

      // Short low glitch: START re-checks at half a bit and returns to IDLE.
      i_clk_div = 16'd16;
      base_rq  = rq_cnt;
      base_err = err_cnt;
      @(negedge clk);
      i_rx = 1'b0;
      hlen = 0;
      for (int c = 0; c < 40; c++) begin
         if (c == 4) i_rx = 1'b1;
         @(negedge clk);
         if (o_rx_busy) hlen++;
      end
      check("glitch_busy_cycles", 32'(hlen), 32'd8);
      check("glitch_idle", 32'(o_rx_busy), 32'd0);
      check("glitch_no_pulse", 32'((rq_cnt - base_rq) + (err_cnt - base_err)), 32'd0);

      // Back-to-back frames with a single stop bit and no gap.
      i_clk_div = 16'd10;
      exp4 = '{8'h11, 8'h22, 8'h33, 8'h44};
      rx_q.delete();
      base_err = err_cnt;
      for (int f = 0; f < 4; f++) send_frame(exp4[f], 10, 1'b1, 0, -1, 16'd0);
      wait_idle("b2b_idle");
      check("b2b_count", 32'(rx_q.size()), 32'd4);
      check("b2b_err", 32'(err_cnt - base_err), 32'd0);
      for (int f = 0; f < 4; f++) begin
         if (f < rx_q.size()) check($sformatf("b2b_data%0d", f), 32'(rx_q[f]), 32'(exp4[f]));
      end

      // Reset in the middle of data bit 4 of 0x5A, then a clean 0xC3.
      i_clk_div = 16'd16;
      d = 8'h5A;
      @(negedge clk);
      i_rx = 1'b0;
      repeat (16) @(negedge clk);
      for (int b = 0; b < 4; b++) begin
         i_rx = d[b];
         repeat (16) @(negedge clk);
      end
      i_rx = d[4];
      repeat (8) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("midframe_reset_outputs", {o_rx_data, o_fifo_rq, o_frame_err, o_rx_busy}, 32'd0);
      i_rx = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      rx_q.delete();
      base_err = err_cnt;
      send_frame(8'hC3, 16, 1'b1, 0, -1, 16'd0);
      wait_idle("after_reset_idle");
      check("after_reset_count", 32'(rx_q.size()), 32'd1);
      check("after_reset_data", 32'(o_rx_data), 32'hC3);
      check("after_reset_err", 32'(err_cnt - base_err), 32'd0);

      // Divisor below the floor, and a divisor change mid-frame.
      i_clk_div = 16'd2;
      base_rq = rq_cnt;
      send_frame(8'h81, 4, 1'b1, 0, -1, 16'd0);
      wait_idle("mindiv_idle");
      check("mindiv_rq", 32'(rq_cnt - base_rq), 32'd1);
      check("mindiv_data", 32'(o_rx_data), 32'h81);
      i_clk_div = 16'd16;
      send_frame(8'h00, 16, 1'b1, 0, -1, 16'd0);
      wait_idle("spacer_idle");
      i_clk_div = 16'd2;
      base_rq = rq_cnt;
      send_frame(8'h81, 4, 1'b1, 0, 3, 16'd16);
      wait_idle("divchg_idle");
      check("divchg_rq", 32'(rq_cnt - base_rq), 32'd1);
      check("divchg_data", 32'(o_rx_data), 32'h81);

      // Randomized frames against a frame-level model.
      mdl_data = o_rx_data;
      m_rq  = rq_cnt;
      m_err = err_cnt;
      for (int k = 0; k < 30; k++) begin
         d    = 8'($urandom_range(0, 255));
         rdiv = 16'($urandom_range(1, 12));
         stop = ($urandom_range(0, 3) != 0);
         hold = $urandom_range(0, 15);
         i_clk_div = rdiv;
         send_frame(d, eff_div(rdiv), stop, hold, -1, 16'd0);
         if (stop) begin
            m_rq++;
            mdl_data = d;
         end else begin
            m_err++;
         end
         wait_idle($sformatf("rand%0d_idle", k));
         check($sformatf("rand%0d_rq", k), 32'(rq_cnt), 32'(m_rq));
         check($sformatf("rand%0d_err", k), 32'(err_cnt), 32'(m_err));
         check($sformatf("rand%0d_data", k), 32'(o_rx_data), 32'(mdl_data));
         repeat ($urandom_range(0, 5)) @(negedge clk);
      end

      check("pulse_exclusive", 32'(viol), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule : tb_uart_rx_deser
